// File: rtl/dmem_stall_responder.sv
// MEM-stage load/store responder: issues one access to a variable-latency data
// memory, stalls the front of the pipeline while it is outstanding, and holds the result.
module dmem_stall_responder #(
   parameter int unsigned TIMEOUT  = 64,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        op_valid,
   input  logic        op_we,
   input  logic [31:0] op_addr,
   input  logic [31:0] op_wdata,
   input  logic        op_flush,
   input  logic        mw_adv,
   output logic        mem_req_valid,
   output logic        mem_req_we,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   input  logic        mem_req_ready,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata,
   output logic        stall_req,
   output logic [31:0] rdata_out,
   output logic        err_timeout
);

   localparam int unsigned CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      err_d         = 1'b0;
      cnt_d         = cnt_q;
      stall_req     = 1'b0;
      mem_req_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (op_valid && !op_flush) begin
               stall_req = 1'b1;
               we_d      = op_we;
               addr_d    = op_addr;
               wdata_d   = op_wdata;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            stall_req     = 1'b1;
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               cnt_d = '0;
               // A zero-wait memory may answer in the accept cycle itself.
               if (mem_rsp_valid) begin
                  if (!we_q) rdata_d = mem_rsp_rdata;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            stall_req = 1'b1;
            if (mem_rsp_valid) begin
               if (!we_q) rdata_d = mem_rsp_rdata;
               state_d = ST_DONE;
            end else if (cnt_q == CNT_LAST) begin
               if (!we_q) rdata_d = ERR_DATA;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            // The finished op is still presented; only MEM/WB advancing releases it.
            if (mw_adv) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mem_req_we    = we_q;
   assign mem_req_addr  = addr_q;
   assign mem_req_wdata = wdata_q;
   assign rdata_out     = rdata_q;
   assign err_timeout   = err_q;

endmodule

// File: tb/tb_dmem_stall_responder.sv
// Scoreboard bench for dmem_stall_responder: a reactive memory model, a stimulus
// process that pushes expectations, and a monitor that pops and compares.
module tb_dmem_stall_responder;

   localparam int unsigned TIMEOUT  = 64;
   localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_we = 1'b0;
   logic [31:0] op_addr = '0;
   logic [31:0] op_wdata = '0;
   logic        op_flush = 1'b0;
   logic        mw_adv = 1'b0;
   logic        mem_req_valid;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic        mem_req_ready = 1'b0;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_rdata = '0;
   logic        stall_req;
   logic [31:0] rdata_out;
   logic        err_timeout;

   dmem_stall_responder #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
      .clk(clk), .rstn(rstn),
      .op_valid(op_valid), .op_we(op_we), .op_addr(op_addr), .op_wdata(op_wdata),
      .op_flush(op_flush), .mw_adv(mw_adv),
      .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_rdata(mem_rsp_rdata),
      .stall_req(stall_req), .rdata_out(rdata_out), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      int          r;      // REQ cycles with ready low before acceptance
      int          d;      // WAIT cycles until response (0: same cycle as ready)
      bit          to;     // never respond
      logic [31:0] rdata;
   } mem_t;

   typedef struct {
      logic [31:0] rdata;
      bit          err;
      int          cycles; // stall_req high cycles for this op
   } cpl_t;

   req_t reqq[$];
   mem_t memq[$];
   cpl_t cplq[$];

   int          checks = 0;
   int          failures = 0;
   logic [31:0] model_rdata = '0;
   logic [31:0] last_rdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Memory: reacts to a visible request, drives ready/response mid-cycle.
   initial begin
      mem_t m;
      forever begin
         @(negedge clk); #1;
         if (mem_req_valid) begin
            if (memq.size() == 0) begin
               chk("mem_unexpected_req", 32'd1, 32'd0);
               mem_req_ready = 1'b1;
               @(negedge clk); #1;
               mem_req_ready = 1'b0;
            end else begin
               m = memq.pop_front();
               mem_req_ready = 1'b0;
               for (int i = 0; i < m.r; i++) begin
                  @(negedge clk); #1;
               end
               mem_req_ready = 1'b1;
               mem_rsp_rdata = $urandom;
               if (!m.to && m.d == 0) begin
                  mem_rsp_valid = 1'b1;
                  mem_rsp_rdata = m.rdata;
               end
               @(negedge clk); #1;
               mem_req_ready = 1'b0;
               mem_rsp_valid = 1'b0;
               if (!m.to && m.d > 0) begin
                  for (int i = 1; i < m.d; i++) begin
                     @(negedge clk); #1;
                  end
                  mem_rsp_valid = 1'b1;
                  mem_rsp_rdata = m.rdata;
                  @(negedge clk); #1;
                  mem_rsp_valid = 1'b0;
                  mem_rsp_rdata = $urandom;
               end
            end
         end
      end
   end

   // Monitor: request fields, completion result, stall length, hold of rdata_out.
   initial begin
      int   stall_run;
      cpl_t c;
      stall_run = 0;
      forever begin
         @(negedge clk); #3;
         if (!rstn) begin
            stall_run = 0;
         end else begin
            if (mem_req_valid) begin
               if (reqq.size() == 0) begin
                  chk("spurious_req", 32'd1, 32'd0);
               end else begin
                  chk("req_we", mem_req_we, reqq[0].we);
                  chk("req_addr", mem_req_addr, reqq[0].addr);
                  chk("req_wdata", mem_req_wdata, reqq[0].wdata);
                  if (mem_req_ready) void'(reqq.pop_front());
               end
            end
            if (stall_req) begin
               chk("rdata_hold", rdata_out, last_rdata);
               chk("err_in_stall", err_timeout, 32'd0);
               stall_run++;
            end else if (stall_run > 0) begin
               if (cplq.size() == 0) begin
                  chk("spurious_completion", 32'd1, 32'd0);
               end else begin
                  c = cplq.pop_front();
                  chk("cpl_rdata", rdata_out, c.rdata);
                  chk("cpl_err", err_timeout, c.err);
                  chk("cpl_stall_cycles", stall_run, c.cycles);
                  last_rdata = c.rdata;
               end
               stall_run = 0;
            end else begin
               chk("err_idle", err_timeout, 32'd0);
            end
         end
      end
   end

   task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int r, input int d, input bit to, input logic [31:0] rd);
      mem_t m;
      req_t q;
      cpl_t c;
      m = '{r: r, d: d, to: to, rdata: rd};
      memq.push_back(m);
      q = '{we: we, addr: addr, wdata: wdata};
      reqq.push_back(q);
      if (!we) model_rdata = to ? ERR_DATA : rd;
      c = '{rdata: model_rdata, err: to, cycles: 2 + r + (to ? int'(TIMEOUT) : d)};
      cplq.push_back(c);
      op_valid = 1'b1;
      op_flush = 1'b0;
      op_we    = we;
      op_addr  = addr;
      op_wdata = wdata;
   endtask

   // Wait for release, hold DONE for 'hold' extra cycles, then advance MEM/WB once.
   task automatic finish_op(input int hold);
      bit seen;
      int n;
      seen = 1'b0;
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (stall_req) seen = 1'b1;
         else if (seen) break;
         if (n > 300) begin
            chk("op_release_bound", 32'd1, 32'd0);
            break;
         end
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("done_stall", stall_req, 32'd0);
         chk("done_no_req", mem_req_valid, 32'd0);
      end
      mw_adv = 1'b1;
      @(posedge clk); #1;
      mw_adv = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] w;
      int          gap;

      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_req_valid", mem_req_valid, 32'd0);
      chk("rst_req_we", mem_req_we, 32'd0);
      chk("rst_req_addr", mem_req_addr, 32'd0);
      chk("rst_req_wdata", mem_req_wdata, 32'd0);
      chk("rst_stall", stall_req, 32'd0);
      chk("rst_rdata", rdata_out, 32'd0);
      chk("rst_err", err_timeout, 32'd0);
      @(posedge clk); #1;

      // zero-wait load
      issue(1'b0, 32'h100, 32'h0, 0, 0, 1'b0, 32'h12345678);
      finish_op(0);
      op_valid = 1'b0;
      @(posedge clk); #1;

      // store with delayed ready and ack
      issue(1'b1, 32'h200, 32'hCAFEF00D, 3, 2, 1'b0, 32'h0);
      finish_op(0);
      op_valid = 1'b0;
      @(posedge clk); #1;

      // load that times out
      issue(1'b0, 32'h300, 32'h0, 1, 0, 1'b1, 32'h0);
      finish_op(1);
      op_valid = 1'b0;
      @(posedge clk); #1;

      // DONE held three cycles with op_valid high, then a new op right after release
      issue(1'b0, 32'h400, 32'h0, 0, 1, 1'b0, 32'hA5A5_0001);
      finish_op(3);
      issue(1'b0, 32'h404, 32'h0, 0, 0, 1'b0, 32'hA5A5_0002);
      @(negedge clk);
      chk("idle_after_release", stall_req, 32'd1);
      finish_op(0);

      // flushed op is never issued
      op_valid = 1'b1;
      op_flush = 1'b1;
      op_addr  = 32'h500;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("flush_stall", stall_req, 32'd0);
         chk("flush_req", mem_req_valid, 32'd0);
         @(posedge clk); #1;
      end
      op_flush = 1'b0;
      op_valid = 1'b0;
      @(posedge clk); #1;

      // reset mid-WAIT, then a late response
      issue(1'b0, 32'h600, 32'h0, 0, 0, 1'b1, 32'h0);
      repeat (6) @(negedge clk);
      chk("wait_stall", stall_req, 32'd1);
      @(posedge clk); #1;
      void'(cplq.pop_back());
      model_rdata = '0;
      last_rdata  = '0;
      rstn        = 1'b0;
      op_valid    = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("midrst_req_valid", mem_req_valid, 32'd0);
      chk("midrst_req_addr", mem_req_addr, 32'd0);
      chk("midrst_stall", stall_req, 32'd0);
      chk("midrst_rdata", rdata_out, 32'd0);
      chk("midrst_err", err_timeout, 32'd0);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 32'h7777_7777;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("late_rsp_rdata", rdata_out, 32'd0);
      chk("late_rsp_stall", stall_req, 32'd0);
      @(posedge clk); #1;
      issue(1'b0, 32'h604, 32'h0, 1, 1, 1'b0, 32'h0BAD_F00D);
      finish_op(0);
      op_valid = 1'b0;
      @(posedge clk); #1;

      // randomized traffic
      for (int k = 0; k < 40; k++) begin
         a = $urandom & 32'hFFFF_FFFC;
         w = $urandom;
         issue(1'($urandom_range(0, 1)), a, w, int'($urandom_range(0, 4)),
               int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0), $urandom);
         finish_op(int'($urandom_range(0, 3)));
         gap = int'($urandom_range(0, 2));
         if (gap > 0) begin
            op_valid = ($urandom_range(0, 1) == 1);
            op_flush = op_valid;
            for (int i = 0; i < gap; i++) begin
               @(negedge clk);
               chk("gap_stall", stall_req, 32'd0);
               @(posedge clk); #1;
            end
            op_flush = 1'b0;
            op_valid = 1'b0;
         end
      end

      op_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); #4;
      chk("reqq_empty", reqq.size(), 32'd0);
      chk("memq_empty", memq.size(), 32'd0);
      chk("cplq_empty", cplq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_stall_responder.md
Name: dmem_stall_responder

Overview:
- Memory-stage responder for the 5-stage pipeline; it is the requester side of the stall/enable interface driven by the hazard detection unit.
- Accepts a load/store from the EX/MEM register and runs it on a variable-latency data memory using a valid/ready request and a valid response.
- Raises stall_req to the hazard unit while the access is outstanding. Holds the load data until the MEM/WB register advances.

Parameters:
- TIMEOUT, 64: maximum cycles waiting for mem_rsp_valid before the access is aborted.
- ERR_DATA, 32'hDEADBEEF: rdata_out value returned on a timed-out load.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rstn  in  1  synchronous active-low reset.
- op_valid  in  1  EX/MEM holds a memory op (MemRead or MemWrite).
- op_we  in  1  1=store, 0=load.
- op_addr  in  32  byte address.
- op_wdata  in  32  store data (already forwarded).
- op_flush  in  1  EX/MEM flush; kills an op not yet issued.
- mw_adv  in  1  MEM/WB register enable (reg_MW_EN) this cycle.
- mem_req_valid  out  1  request to memory.
- mem_req_we  out  1  request is a write.
- mem_req_addr  out  32  request address.
- mem_req_wdata  out  32  request write data.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_rsp_valid  in  1  memory response (read data or write ack).
- mem_rsp_rdata  in  32  read data.
- stall_req  out  1  to hazard unit: freeze PC, IF/ID, ID/EX, EX/MEM.
- rdata_out  out  32  load result for the MEM/WB register.
- err_timeout  out  1  one-cycle pulse when an access times out.

Behaviour:
- Reset (rstn=0 at a clock edge): state=IDLE; all outputs 0 (mem_req_*, stall_req, rdata_out, err_timeout); timeout counter=0. Reset mid-access abandons the access. A late mem_rsp_valid arriving in IDLE is ignored.
- stall_req is combinational:
  - 1 in IDLE when op_valid=1 and op_flush=0.
  - 1 in REQ and in WAIT.
  - 0 in DONE.
- States and transitions:
  - IDLE: if op_valid=1 and op_flush=0, latch op_we, op_addr and op_wdata, then go to REQ. If op_flush=1, stay in IDLE with no request and no stall.
  - REQ: mem_req_valid=1 with the latched fields, held stable until mem_req_ready. On ready, go to WAIT and clear the counter. If mem_rsp_valid arrives in the same cycle as ready, go directly to DONE and capture the data.
  - WAIT: counter increments each cycle. On mem_rsp_valid, capture rdata_out (loads only; stores leave rdata_out unchanged) and go to DONE. If the counter reaches TIMEOUT-1 without a response, set rdata_out=ERR_DATA for loads, pulse err_timeout, and go to DONE.
  - DONE: stall_req=0, so the pipeline advances. Leave DONE only when mw_adv=1. If mw_adv=1, go to IDLE; this is one cycle at minimum. If mw_adv=0, stay in DONE, so the completed op is never reissued.
- An op must not be accepted from DONE even if op_valid=1, because the same instruction is still presented. The minimum gap between back-to-back ops is therefore one IDLE-evaluation cycle, which is the cycle after DONE.
- The REQ timeout counter does not run; the memory ready backpressure is unbounded.
- rdata_out holds its value from capture until the next load capture.
- Latency, first stall cycle to release: 1 (IDLE) + REQ cycles + WAIT cycles. With a zero-wait memory (ready=1 and rsp_valid=1 in the same REQ cycle), stall_req is high for 2 cycles (IDLE, REQ) and DONE is in cycle 3.
- Width: the counter is clog2(TIMEOUT)+1 bits and saturates; no wraparound.

Test Plan:
1. Load, addr=0x100, memory ready=1 and rsp in the same cycle with rdata=0x12345678 -> stall_req high 2 cycles, DONE next cycle, rdata_out=0x12345678, mem_req_valid high exactly 1 cycle.
2. Store, addr=0x200, wdata=0xCAFEF00D, ready delayed 3 cycles, ack 2 cycles later -> mem_req_* stable for 4 cycles, stall_req high until DONE, rdata_out unchanged, single write seen.
3. Load with no response, TIMEOUT=64 -> err_timeout pulses once 64 cycles after WAIT entry, rdata_out=0xDEADBEEF, FSM returns to IDLE after mw_adv.
4. DONE with mw_adv=0 for 3 cycles while op_valid stays 1 -> no second mem_req_valid, stall_req=0 throughout; back to IDLE one cycle after mw_adv=1.
5. op_valid=1 together with op_flush=1 -> no request, stall_req=0, state stays IDLE.
6. rstn=0 during WAIT, then a late mem_rsp_valid -> outputs 0 after the reset edge, response ignored, next load completes normally.
